// File: rtl/npu_fp_pkg.sv
// Shared FP32 types and sequencer state encoding for the NPU FP datapath.
// Imported by the accumulation sequencer and its neighbours.
package npu_fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } fp32_t;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } acc_state_e;

endpackage

// File: rtl/fp32_acc_seq.sv
// FP32 group accumulator sequencer: folds each input element into a running
// sum through an external 2-stage adder and emits one sum+count per group.
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_data/i_last/i_valid     element stream in, o_ready back
//   o_add_a/o_add_b/o_add_valid, i_add_ready   operands toward adder
//   i_add_result/i_add_valid, o_add_ready      sum back from adder
//   o_sum/o_count/o_valid, i_ready             group result out
module fp32_acc_seq
  import npu_fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_data,
  input  logic             i_last,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  output logic             o_add_valid,
  input  logic             i_add_ready,
  input  logic [31:0]      i_add_result,
  input  logic             i_add_valid,
  output logic             o_add_ready,
  output logic [31:0]      o_sum,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  acc_state_e       state_q, state_d;
  fp32_t            acc_q, acc_d;
  logic [31:0]      op_b_q, op_b_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_b_d  = op_b_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          op_b_d  = i_data;
          last_d  = i_last;
          // Saturate instead of wrapping; the sum is unaffected.
          if (count_q != '1) count_d = count_q + CNT_ONE;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_add_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_add_valid) begin
          acc_d   = i_add_result;
          state_d = last_q ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          acc_d   = FP32_POS_ZERO;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      acc_q   <= FP32_POS_ZERO;
      op_b_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_b_q  <= op_b_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_add_valid = (state_q == S_ISSUE);
  assign o_add_ready = (state_q == S_WAIT);
  assign o_valid     = (state_q == S_OUT);
  assign o_add_a     = acc_q;
  assign o_add_b     = op_b_q;
  assign o_sum       = acc_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_fp32_acc_seq.sv
// Scoreboard bench for fp32_acc_seq with a behavioural 2-cycle FP32 adder.
// Instance 0 uses CNT_W=16, instance 1 uses CNT_W=2 for saturation.
module tb_fp32_acc_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        vld   [2];
  logic [31:0] dat   [2];
  logic        lst   [2];
  logic        rdy_o [2];
  logic [31:0] add_a [2];
  logic [31:0] add_b [2];
  logic        add_v [2];
  logic        add_r [2];
  logic [31:0] res   [2];
  logic        res_v [2];
  logic        res_r [2];
  logic [31:0] sum   [2];
  logic [15:0] cnt   [2];
  logic        ov    [2];
  logic        ir    [2];
  logic        stall [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  assign cnt[0] = cnt0;
  assign cnt[1] = {14'b0, cnt1};

  fp32_acc_seq #(.CNT_W(16)) u_dut0 (
    .i_clk(clk), .i_reset(rst),
    .i_data(dat[0]), .i_last(lst[0]), .i_valid(vld[0]),
    .o_ready(rdy_o[0]),
    .o_add_a(add_a[0]), .o_add_b(add_b[0]),
    .o_add_valid(add_v[0]), .i_add_ready(add_r[0]),
    .i_add_result(res[0]), .i_add_valid(res_v[0]),
    .o_add_ready(res_r[0]),
    .o_sum(sum[0]), .o_count(cnt0), .o_valid(ov[0]),
    .i_ready(ir[0])
  );

  fp32_acc_seq #(.CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_data(dat[1]), .i_last(lst[1]), .i_valid(vld[1]),
    .o_ready(rdy_o[1]),
    .o_add_a(add_a[1]), .o_add_b(add_b[1]),
    .o_add_valid(add_v[1]), .i_add_ready(add_r[1]),
    .i_add_result(res[1]), .i_add_valid(res_v[1]),
    .o_add_ready(res_r[1]),
    .o_sum(sum[1]), .o_count(cnt1), .o_valid(ov[1]),
    .i_ready(ir[1])
  );

  function automatic real f2r(logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b0, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_add
    logic        v1, v2;
    logic [31:0] s1, s2;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        s1 <= '0;
        s2 <= '0;
      end else begin
        v1 <= add_v[g] && add_r[g];
        if (add_v[g] && add_r[g])
          s1 <= r2f(f2r(add_a[g]) + f2r(add_b[g]));
        if (v1) begin
          v2 <= 1'b1;
          s2 <= s1;
        end else if (v2 && res_r[g]) begin
          v2 <= 1'b0;
        end
      end
    end
    assign add_r[g] = ~stall[g];
    assign res[g]   = s2;
    assign res_v[g] = v2;
  end

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [47:0] act, logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  typedef struct {
    int          tag;
    logic [31:0] sum;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  function automatic void expect_grp(int g, logic [31:0] s, logic [15:0] c);
    exp_t e;
    e.tag = g;
    e.sum = s;
    e.cnt = c;
    exp_q.push_back(e);
  endfunction

  int  rise_cyc = 0;
  logic ov0_prev = 1'b0;

  always @(negedge clk) begin
    if (ov[0] && !ov0_prev) rise_cyc = cyc;
    ov0_prev = ov[0];
    for (int g = 0; g < 2; g++) begin
      if (!rst && ov[g] && ir[g]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result dut=%0d sum=%h cnt=%0d",
                   g, sum[g], cnt[g]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_dut", 48'(g), 48'(e.tag));
          chk("result_sum", {16'b0, sum[g]}, {16'b0, e.sum});
          chk("result_cnt", {32'b0, cnt[g]}, {32'b0, e.cnt});
        end
      end
    end
  end

  int last_acc = 0;

  task automatic send(input int g, input logic [31:0] d, input logic l);
    int n;
    vld[g] = 1'b1;
    dat[g] = d;
    lst[g] = l;
    n = 0;
    while (!rdy_o[g] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut=%0d data=%h", g, d);
    end else begin
      last_acc = cyc;
      @(posedge clk);
      #1;
    end
    vld[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && rdy_o[g]) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout dut=%0d pending=%0d", g, exp_q.size());
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ready"}, 48'(rdy_o[0]), 48'd1);
    chk({nm, "_addv"}, 48'(add_v[0]), 48'd0);
    chk({nm, "_addr"}, 48'(res_r[0]), 48'd0);
    chk({nm, "_valid"}, 48'(ov[0]), 48'd0);
    chk({nm, "_sum"}, 48'(sum[0]), 48'd0);
    chk({nm, "_cnt"}, 48'(cnt[0]), 48'd0);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      vld[g] = 1'b0;
      dat[g] = '0;
      lst[g] = 1'b0;
      ir[g] = 1'b1;
      stall[g] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk);
    #1;

    // Three-element group and result latency
    expect_grp(0, 32'h40C00000, 16'd3);
    send(0, 32'h3F800000, 1'b0);
    send(0, 32'h40000000, 1'b0);
    send(0, 32'h40400000, 1'b1);
    wait_idle(0);
    chk("latency", 48'(rise_cyc - last_acc), 48'd4);

    // Single-element groups back to back
    expect_grp(0, 32'h3F000000, 16'd1);
    send(0, 32'h3F000000, 1'b1);
    expect_grp(0, 32'h3FC00000, 16'd1);
    send(0, 32'h3FC00000, 1'b1);
    wait_idle(0);

    // Cancellation to +0
    expect_grp(0, 32'h00000000, 16'd2);
    send(0, 32'h3F800000, 1'b0);
    send(0, 32'hBF800000, 1'b1);
    wait_idle(0);

    // Output backpressure with a competing input
    ir[0] = 1'b0;
    expect_grp(0, 32'h40800000, 16'd2);
    send(0, 32'h40000000, 1'b0);
    send(0, 32'h40000000, 1'b1);
    begin
      int n;
      n = 0;
      while (!ov[0] && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("bp_reach_out", 48'(ov[0]), 48'd1);
    end
    vld[0] = 1'b1;
    dat[0] = 32'h3F800000;
    lst[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 48'(ov[0]), 48'd1);
      chk("bp_sum", 48'(sum[0]), 48'h40800000);
      chk("bp_cnt", 48'(cnt[0]), 48'd2);
      chk("bp_ready", 48'(rdy_o[0]), 48'd0);
    end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    ir[0] = 1'b1;
    wait_idle(0);

    // Adder backpressure: operands held
    stall[0] = 1'b1;
    expect_grp(0, 32'h40000000, 16'd2);
    send(0, 32'h3F800000, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_addv", 48'(add_v[0]), 48'd1);
      chk("stall_a", 48'(add_a[0]), 48'h0);
      chk("stall_b", 48'(add_b[0]), 48'h3F800000);
    end
    @(posedge clk);
    #1;
    stall[0] = 1'b0;
    send(0, 32'h3F800000, 1'b1);
    wait_idle(0);

    // Reset while waiting on the adder
    send(0, 32'h3F800000, 1'b0);
    send(0, 32'h40000000, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_wait", 48'(res_r[0]), 48'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    chk("midrst_a", 48'(add_a[0]), 48'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_grp(0, 32'h40000000, 16'd1);
    send(0, 32'h40000000, 1'b1);
    wait_idle(0);

    // Counter saturation on the narrow instance
    expect_grp(1, 32'h40A00000, 16'd3);
    for (int i = 0; i < 5; i++)
      send(1, 32'h3F800000, (i == 4));
    wait_idle(1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
